// File: rtl/mc_main_ctrlr.sv
// Multicycle main control FSM for the MIPS-variant datapath.
// Sequences fetch/decode/execute/memory/writeback and counts retirements.
module mc_main_ctrlr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [8:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       aluop,
  output logic             reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             spec_write,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [8:0] FN_MVTO = 9'h001;
  localparam logic [8:0] FN_MVFR = 9'h002;
  localparam logic [8:0] FN_NOP  = 9'h080;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_MOVE
  } state_t;

  state_t     state;
  state_t     nstate;
  logic       lat_lw;
  logic       lat_mvto;
  logic [2:0] lat_iop;
  logic       retire;
  logic       set_ill;
  logic [2:0] dec_iop;

  // zero only steers the PC through pc_write_cond in the datapath
  logic unused_zero;
  assign unused_zero = zero;

  // immediate-op ALU code derived from the live opcode
  always_comb begin
    dec_iop = 3'd0;
    case (opcode)
      OP_ANDI: dec_iop = 3'd4;
      OP_ORI:  dec_iop = 3'd5;
      default: dec_iop = 3'd0;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= nstate;
  end

  // capture instruction variants in DECODE so later IR changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_lw   <= 1'b0;
      lat_mvto <= 1'b0;
      lat_iop  <= 3'd0;
    end else if (state == S_DECODE) begin
      lat_lw   <= (opcode == OP_LW);
      lat_mvto <= (func == FN_MVTO);
      lat_iop  <= dec_iop;
    end
  end

  // retirement counter and sticky illegal-opcode flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired    <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (retire)  retired    <= retired + 1'b1;
      if (set_ill) illegal_op <= 1'b1;
    end
  end

  // next state and control outputs
  always_comb begin
    nstate        = state;
    retire        = 1'b0;
    set_ill       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    aluop         = 3'd3;
    reg_dst       = 1'b0;
    mem_to_reg    = 2'd0;
    reg_write     = 1'b0;
    spec_write    = 1'b0;
    unique case (state)
      S_INIT: begin
        aluop  = 3'd0;
        nstate = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        aluop     = 3'd0;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) nstate = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        aluop     = 3'd0;
        case (opcode)
          OP_LW, OP_SW: nstate = S_MEM_ADR;
          OP_RTYPE: begin
            if (func == FN_MVTO || func == FN_MVFR) begin
              nstate = S_MOVE;
            end else if (func == FN_NOP) begin
              nstate = S_FETCH;
              retire = 1'b1;
            end else begin
              nstate = S_EXEC_R;
            end
          end
          OP_ADDI, OP_ANDI, OP_ORI: nstate = S_EXEC_I;
          OP_BEQ: nstate = S_BRANCH;
          OP_J:   nstate = S_JUMP;
          default: begin
            nstate  = S_FETCH;
            set_ill = 1'b1;
          end
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        aluop     = 3'd0;
        nstate    = lat_lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) nstate = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        retire     = 1'b1;
        nstate     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          nstate = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        aluop     = 3'd2;
        nstate    = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        aluop     = 3'd2;
        retire    = 1'b1;
        nstate    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        aluop     = lat_iop;
        nstate    = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        nstate    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = 3'd1;
        pc_write_cond = 1'b1;
        pc_src        = 2'd1;
        retire        = 1'b1;
        nstate        = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
        retire   = 1'b1;
        nstate   = S_FETCH;
      end
      S_MOVE: begin
        if (lat_mvto) begin
          spec_write = 1'b1;
          alu_src_a  = 1'b1;
        end else begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          mem_to_reg = 2'd2;
        end
        retire = 1'b1;
        nstate = S_FETCH;
      end
      default: nstate = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_mc_main_ctrlr.sv
// Bench for mc_main_ctrlr: per-instruction expected control words
// built from the instruction class, checked every cycle.
module tb_mc_main_ctrlr;

  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;

  typedef struct packed {
    logic       mr;
    logic       mw;
    logic       iord;
    logic       irw;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       rdst;
    logic [1:0] m2r;
    logic       rw;
    logic       sw;
    logic       ill;
    logic [3:0] ret;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [8:0] func;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write;
  logic       pc_write, pc_write_cond;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] aluop;
  logic       reg_dst;
  logic [1:0] mem_to_reg;
  logic       reg_write, spec_write, illegal_op;
  logic [3:0] retired;

  mc_main_ctrlr #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .spec_write(spec_write),
    .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  ov_t act;
  assign act = {mem_read, mem_write, iord, ir_write, pc_write,
                pc_write_cond, pc_src, alu_src_a, alu_src_b, aluop,
                reg_dst, mem_to_reg, reg_write, spec_write,
                illegal_op, retired};

  int         n_chk = 0;
  int         n_fail = 0;
  int         n_cyc;
  ov_t        expq[$];
  logic [2:0] aop_hist[$];
  logic [3:0] mret = 4'd0;
  logic       mill = 1'b0;
  int         n;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, x);
    end
  endtask

  // every-cycle comparison against the model's expected word
  always @(negedge clk) begin
    if (expq.size() > 0) chk("outputs", act, expq.pop_front());
  end

  function automatic ov_t z();
    ov_t e;
    e = '0;
    e.aop = 3'd3;
    return e;
  endfunction

  task automatic cyc(input ov_t e, input logic rdy);
    mem_ready = rdy;
    e.ret = mret;
    e.ill = mill;
    aop_hist.push_back(aluop);
    expq.push_back(e);
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic fetch(input int fw);
    ov_t e;
    for (int i = 0; i < fw; i++) begin
      e = z(); e.mr = 1; e.asb = 2'd1; e.aop = 3'd0;
      cyc(e, 1'b0);
    end
    e = z(); e.mr = 1; e.asb = 2'd1; e.aop = 3'd0;
    e.irw = 1; e.pcw = 1;
    cyc(e, 1'b1);
  endtask

  task automatic run(input logic [5:0] op, input logic [8:0] fn,
                     input logic zf, input int fw, input int mw,
                     output int cnt);
    ov_t e;
    n_cyc = 0;
    aop_hist.delete();
    opcode = op;
    func = fn;
    zero = zf;
    fetch(fw);
    e = z(); e.asb = 2'd3; e.aop = 3'd0;
    cyc(e, 1'b1);
    opcode = op ^ 6'h2a;
    func = {fn[0], fn[8:1]};
    case (op)
      RT: begin
        if (fn == 9'h001 || fn == 9'h002) begin
          e = z();
          if (fn == 9'h001) begin e.sw = 1; e.asa = 1; end
          else begin e.rw = 1; e.rdst = 1; e.m2r = 2'd2; end
          cyc(e, 1'b1);
          mret = mret + 4'd1;
        end else if (fn == 9'h080) begin
          mret = mret + 4'd1;
        end else begin
          e = z(); e.asa = 1; e.aop = 3'd2;
          cyc(e, 1'b1);
          e = z(); e.rw = 1; e.rdst = 1; e.aop = 3'd2;
          cyc(e, 1'b1);
          mret = mret + 4'd1;
        end
      end
      ADDI, ANDI, ORI: begin
        e = z(); e.asa = 1; e.asb = 2'd2;
        e.aop = (op == ANDI) ? 3'd4 : (op == ORI) ? 3'd5 : 3'd0;
        cyc(e, 1'b1);
        e = z(); e.rw = 1;
        cyc(e, 1'b1);
        mret = mret + 4'd1;
      end
      LW, SW: begin
        e = z(); e.asa = 1; e.asb = 2'd2; e.aop = 3'd0;
        cyc(e, 1'b1);
        e = z(); e.iord = 1;
        if (op == LW) e.mr = 1; else e.mw = 1;
        for (int i = 0; i < mw; i++) cyc(e, 1'b0);
        cyc(e, 1'b1);
        if (op == LW) begin
          e = z(); e.rw = 1; e.m2r = 2'd1;
          cyc(e, 1'b1);
        end
        mret = mret + 4'd1;
      end
      BEQ: begin
        e = z(); e.asa = 1; e.aop = 3'd1; e.pcwc = 1; e.pcs = 2'd1;
        cyc(e, 1'b1);
        mret = mret + 4'd1;
      end
      JMP: begin
        e = z(); e.pcw = 1; e.pcs = 2'd2;
        cyc(e, 1'b1);
        mret = mret + 4'd1;
      end
      default: mill = 1'b1;
    endcase
    cnt = n_cyc;
  endtask

  initial begin
    ov_t e;
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'd0;
    func = 9'd0;
    zero = 1'b0;
    @(posedge clk);
    #1;
    cyc('0, 1'b0);
    rst = 1'b0;
    cyc('0, 1'b1);
    chk("rst_retired", {28'd0, retired}, 32'd0);

    run(RT, 9'h004, 1'b0, 0, 0, n);
    chk("r_cycles", n, 4);
    chk("r_aluop_exec", {29'd0, aop_hist[2]}, 32'd2);
    chk("r_retired", {28'd0, retired}, 32'd1);
    run(LW, 9'h000, 1'b0, 0, 3, n);
    chk("lw_wait_cycles", n, 8);
    chk("lw_retired", {28'd0, retired}, 32'd2);
    run(SW, 9'h000, 1'b0, 1, 0, n);
    chk("sw_fetchwait_cycles", n, 5);
    run(BEQ, 9'h000, 1'b1, 0, 0, n);
    chk("beq_taken_cycles", n, 3);
    chk("beq_aluop", {29'd0, aop_hist[2]}, 32'd1);
    run(BEQ, 9'h000, 1'b0, 0, 0, n);
    chk("beq_not_cycles", n, 3);
    run(JMP, 9'h000, 1'b0, 0, 0, n);
    chk("j_cycles", n, 3);
    run(RT, 9'h001, 1'b0, 0, 0, n);
    chk("moveto_cycles", n, 3);
    run(RT, 9'h002, 1'b0, 0, 0, n);
    chk("movefrom_cycles", n, 3);
    run(RT, 9'h080, 1'b0, 0, 0, n);
    chk("nop_cycles", n, 2);
    run(ADDI, 9'h000, 1'b0, 0, 0, n);
    chk("addi_cycles", n, 4);
    run(ORI, 9'h000, 1'b0, 0, 0, n);
    chk("ori_aluop", {29'd0, aop_hist[2]}, 32'd5);
    run(6'b111111, 9'h000, 1'b0, 0, 0, n);
    chk("illegal_cycles", n, 2);
    chk("illegal_flag", {31'd0, illegal_op}, 32'd1);
    chk("illegal_noretire", {28'd0, retired}, 32'd11);
    run(ANDI, 9'h000, 1'b0, 0, 0, n);
    chk("andi_aluop", {29'd0, aop_hist[2]}, 32'd4);
    chk("sticky_illegal", {31'd0, illegal_op}, 32'd1);

    opcode = SW;
    func = 9'd0;
    fetch(0);
    e = z(); e.asb = 2'd3; e.aop = 3'd0;
    cyc(e, 1'b1);
    e = z(); e.asa = 1; e.asb = 2'd2; e.aop = 3'd0;
    cyc(e, 1'b1);
    e = z(); e.mw = 1; e.iord = 1;
    cyc(e, 1'b0);
    mem_ready = 1'b0;
    #2;
    chk("sw_wr_before_rst", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async", act, 32'd0);
    mret = 4'd0;
    mill = 1'b0;
    @(posedge clk);
    #1;
    cyc('0, 1'b0);
    rst = 1'b0;
    cyc('0, 1'b1);
    run(JMP, 9'h000, 1'b0, 0, 0, n);
    chk("post_rst_retired", {28'd0, retired}, 32'd1);

    for (int i = 0; i < 16; i++) run(RT, 9'h080, 1'b0, 0, 0, n);
    chk("wrap_retired", {28'd0, retired}, 32'd1);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_main_ctrlr.md
Name: mc_main_ctrlr

Overview:
- Multicycle main control FSM for the MIPS-variant datapath.
- Decodes opcode and one-hot func, and sequences fetch/decode/execute/memory/writeback.
- Drives all datapath mux selects and enables, plus the 3-bit aluop consumed by the ALU control decoder.
- Stalls on a memory-ready handshake and keeps a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
opcode  in  6  IR[31:26]
func  in  9  IR[8:0], one-hot function field
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  address mux: 0=PC, 1=ALUOut
ir_write  out  1  IR load enable
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero
pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  0=B, 1=const 4, 2=sext imm, 3=sext imm<<2
aluop  out  3  0 add, 1 sub, 2 func-decode, 3 nop, 4 and, 5 or
reg_dst  out  1  0=rt, 1=rd
mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=special reg
reg_write  out  1  register file write
spec_write  out  1  special register write (moveTo)
illegal_op  out  1  sticky, unknown opcode seen
retired  out  CNT_W  instructions completed

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high, named rst. On rst: state=INIT, retired=0, illegal_op=0.
- Output defaults: every output not listed for a state is 0. aluop defaults to 3 (nop).
- Opcodes: RTYPE 000000, ADDI 001000, ANDI 001100, ORI 001101, LW 100011, SW 101011, BEQ 000100, J 000010.
- INIT: all outputs 0. Next state FETCH.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, aluop=0. ir_write=pc_write=mem_ready (Mealy). Stay while !mem_ready; on mem_ready go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, aluop=0 (branch target to ALUOut). Next state by opcode:
  - LW/SW -> MEM_ADR
  - RTYPE with func moveTo (9'h001) or moveFrom (9'h002) -> MOVE
  - RTYPE with func nop (9'h080) -> FETCH (retires)
  - other RTYPE -> EXEC_R
  - ADDI/ANDI/ORI -> EXEC_I
  - BEQ -> BRANCH
  - J -> JUMP
  - unknown opcode -> FETCH, set illegal_op, no retire
- MEM_ADR: alu_src_a=1, alu_src_b=2, aluop=0. LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, aluop=2. Next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, aluop=2. Next FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, aluop = 0 for ADDI, 4 for ANDI, 5 for ORI, latched from opcode in DECODE. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, aluop=1, pc_write_cond=1, pc_src=1. Next FETCH.
- JUMP: pc_write=1, pc_src=2. Next FETCH.
- MOVE:
  - moveTo: spec_write=1, alu_src_a=1.
  - moveFrom: reg_write=1, reg_dst=1, mem_to_reg=2.
  - Next FETCH.
- Latency, zero-wait memory: R/I-type 4 cycles FETCH-to-FETCH; LW 5; SW 4; BEQ, J, MOVE 3; nop 2. Each !mem_ready cycle adds one cycle.
- Retire: retired increments by 1 on the clock edge that leaves MEM_WB, MEM_WR (with mem_ready), R_WB, I_WB, BRANCH, JUMP, MOVE, or DECODE for nop. Wraps from all-ones to 0. Never increments for an illegal opcode.
- mem_ready while no memory request is outstanding: ignored.
- rst mid-instruction: immediate return to INIT. No partially asserted write enables survive, since all outputs are 0 in INIT.
- opcode/func are sampled only in DECODE. EXEC_I and MOVE use variants latched in DECODE, so IR changes after DECODE have no effect.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately, retired=0; release -> INIT for 1 cycle, then FETCH with mem_read=1, alu_src_b=1.
- R-type add, func=9'h004, mem_ready=1 -> states FETCH, DECODE, EXEC_R, R_WB; aluop=2 in EXEC_R; reg_write=1 and reg_dst=1 in R_WB; retired=1 after 4 cycles.
- LW with mem_ready low for 3 cycles in MEM_RD -> mem_read=1, iord=1 held 4 cycles; then MEM_WB with mem_to_reg=1; total 8 cycles; retired increments once.
- BEQ with zero=1, then BEQ with zero=0 -> BRANCH asserts aluop=1, pc_write_cond=1, pc_src=1 in both cases; each takes 3 cycles.
- Illegal opcode 6'b111111 -> DECODE returns to FETCH, illegal_op=1 sticky, retired unchanged; a following ANDI drives aluop=4 in EXEC_I.
- SW in MEM_WR with rst asserted -> mem_write drops immediately; after release, sequence restarts INIT -> FETCH with retired=0.
